// File: rtl/stft_sample_seq_pkg.sv
// Shared defaults and FSM encoding for the STFT sample sequencer.
package stft_pkg;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_FFT_SIZE   = 512;
    localparam int DEF_DISP_DECIM = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIFF  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/stft_sample_seq_sample_ram.sv
// Sample delay line: simple dual-port RAM with 1-cycle synchronous read, no reset.
module sample_ram
    import stft_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int DEPTH      = DEF_FFT_SIZE,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [WORD_WIDTH-1:0] o_rd_data
);

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_rd_data;

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/stft_sample_seq.sv
// Sliding-DFT sample sequencer: forms x[n]-x[n-N] and sweeps all N bins per accepted sample.
module stft_sample_seq
    import stft_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int FFT_SIZE   = DEF_FFT_SIZE,
    parameter int DISP_DECIM = DEF_DISP_DECIM,
    localparam int AW        = $clog2(FFT_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_sample_valid,
    input  logic signed [WORD_WIDTH-1:0] i_sample,
    output logic                         o_sample_ready,
    output logic signed [WORD_WIDTH-1:0] o_sample_diff,
    output logic                         o_rd_en,
    output logic [AW-1:0]                o_rd_addr,
    output logic [AW-1:0]                o_idx,
    output logic                         o_wr_en,
    output logic                         o_disp_wr_en,
    output logic                         o_frame_done
);

    localparam int DW = (DISP_DECIM > 1) ? $clog2(DISP_DECIM) : 1;
    localparam logic [AW-1:0] LAST_BIN   = AW'(FFT_SIZE - 1);
    localparam logic [AW:0]   FILL_FULL  = (AW+1)'(FFT_SIZE);
    localparam logic [DW-1:0] LAST_SWEEP = DW'(DISP_DECIM - 1);

    state_t                        r_state;
    logic signed [WORD_WIDTH-1:0]  r_sample;
    logic signed [WORD_WIDTH-1:0]  r_sample_diff;
    logic [AW-1:0]                 r_wp;
    logic [AW-1:0]                 r_rd_addr;
    logic [AW-1:0]                 r_idx;
    logic [AW:0]                   r_fill;
    logic [DW-1:0]                 r_sweep;
    logic                          r_rd_en;
    logic                          r_wr_en;
    logic                          r_disp_wr_en;
    logic                          r_frame_done;

    logic                          w_accept;
    logic                          w_ram_wr;
    logic signed [WORD_WIDTH-1:0]  w_ram_q;
    logic signed [WORD_WIDTH-1:0]  w_old;
    logic signed [WORD_WIDTH:0]    w_diff_wide;
    logic signed [WORD_WIDTH-1:0]  w_diff_sat;

    function automatic logic signed [WORD_WIDTH-1:0] sat_word(input logic signed [WORD_WIDTH:0] v);
        if (v[WORD_WIDTH] != v[WORD_WIDTH-1]) begin
            if (v[WORD_WIDTH]) begin
                sat_word = {1'b1, {(WORD_WIDTH-1){1'b0}}};
            end else begin
                sat_word = {1'b0, {(WORD_WIDTH-1){1'b1}}};
            end
        end else begin
            sat_word = v[WORD_WIDTH-1:0];
        end
    endfunction

    // Ready is gated by reset_n so it drops during reset and rises right after release.
    assign o_sample_ready = reset_n & (r_state == ST_IDLE);
    assign w_accept       = i_sample_valid & o_sample_ready;
    assign w_ram_wr       = (r_state == ST_DIFF);

    // Until the delay line has been filled once, its stale contents are masked to zero.
    assign w_old       = (r_fill == FILL_FULL) ? w_ram_q : {WORD_WIDTH{1'b0}};
    assign w_diff_wide = {r_sample[WORD_WIDTH-1], r_sample} - {w_old[WORD_WIDTH-1], w_old};
    assign w_diff_sat  = sat_word(w_diff_wide);

    sample_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (FFT_SIZE)
    ) u_sample_ram (
        .clk        (clk),
        .i_wr_en    (w_ram_wr),
        .i_wr_addr  (r_wp),
        .i_wr_data  (r_sample),
        .i_rd_en    (w_accept),
        .i_rd_addr  (r_wp),
        .o_rd_data  (w_ram_q)
    );

    // Sequencer FSM with registered memory, SPU and display strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_sample      <= {WORD_WIDTH{1'b0}};
            r_sample_diff <= {WORD_WIDTH{1'b0}};
            r_wp          <= {AW{1'b0}};
            r_fill        <= {(AW+1){1'b0}};
            r_sweep       <= {DW{1'b0}};
            r_rd_en       <= 1'b0;
            r_rd_addr     <= {AW{1'b0}};
            r_wr_en       <= 1'b0;
            r_idx         <= {AW{1'b0}};
            r_disp_wr_en  <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_wr_en      <= r_rd_en;
            r_idx        <= r_rd_addr;
            r_disp_wr_en <= r_rd_en & (r_sweep == LAST_SWEEP);
            r_frame_done <= 1'b0;
            if (r_frame_done) begin
                r_sweep <= (r_sweep == LAST_SWEEP) ? {DW{1'b0}} : r_sweep + DW'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sample <= i_sample;
                        r_state  <= ST_DIFF;
                    end
                end
                ST_DIFF: begin
                    r_sample_diff <= w_diff_sat;
                    r_wp          <= (r_wp == LAST_BIN) ? {AW{1'b0}} : r_wp + AW'(1);
                    if (r_fill != FILL_FULL) begin
                        r_fill <= r_fill + (AW+1)'(1);
                    end
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= {AW{1'b0}};
                    r_state   <= ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (r_rd_addr == LAST_BIN) begin
                        r_rd_en      <= 1'b0;
                        r_rd_addr    <= {AW{1'b0}};
                        r_frame_done <= 1'b1;
                        r_state      <= ST_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sample_diff = r_sample_diff;
    assign o_rd_en       = r_rd_en;
    assign o_rd_addr     = r_rd_addr;
    assign o_idx         = r_idx;
    assign o_wr_en       = r_wr_en;
    assign o_disp_wr_en  = r_disp_wr_en;
    assign o_frame_done  = r_frame_done;

endmodule

// File: tb/tb_stft_sample_seq.sv
// Randomized bench for stft_sample_seq against a queue-based reference model (reduced FFT_SIZE).
module tb_stft_sample_seq;

    localparam int W  = 16;
    localparam int N  = 32;
    localparam int D  = 4;
    localparam int AW = $clog2(N);

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 i_sample_valid;
    logic signed [W-1:0]  i_sample;
    logic                 o_sample_ready;
    logic signed [W-1:0]  o_sample_diff;
    logic                 o_rd_en;
    logic [AW-1:0]        o_rd_addr;
    logic [AW-1:0]        o_idx;
    logic                 o_wr_en;
    logic                 o_disp_wr_en;
    logic                 o_frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int hist[$];
    int sweeps_done;
    int prev_diff;
    int disp_seen;

    always #5 clk = ~clk;

    stft_sample_seq #(
        .WORD_WIDTH (W),
        .FFT_SIZE   (N),
        .DISP_DECIM (D)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .o_sample_ready (o_sample_ready),
        .o_sample_diff  (o_sample_diff),
        .o_rd_en        (o_rd_en),
        .o_rd_addr      (o_rd_addr),
        .o_idx          (o_idx),
        .o_wr_en        (o_wr_en),
        .o_disp_wr_en   (o_disp_wr_en),
        .o_frame_done   (o_frame_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat_w(input int v);
        int hi;
        int lo;
        hi = (1 << (W - 1)) - 1;
        lo = -(1 << (W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [63:0] pack(input logic rdy, input logic fd, input logic disp,
                                         input logic wr, input logic rd, input logic [AW-1:0] idx,
                                         input logic [AW-1:0] addr, input logic [W-1:0] diff);
        return 64'({rdy, fd, disp, wr, rd, idx, addr, diff});
    endfunction

    function automatic logic [63:0] obs_vec();
        return pack(o_sample_ready, o_frame_done, o_disp_wr_en, o_wr_en, o_rd_en,
                    o_idx, o_rd_addr, o_sample_diff);
    endfunction

    // Expected outputs c cycles after the accept cycle.
    function automatic logic [63:0] expect_vec(input int c, input int diff, input bit disp_sweep);
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [AW-1:0] idx;
        rd   = (c >= 2) && (c <= N + 1);
        wr   = (c >= 3) && (c <= N + 2);
        addr = rd ? AW'(c - 2) : {AW{1'b0}};
        idx  = wr ? AW'(c - 3) : {AW{1'b0}};
        return pack(c == N + 3, c == N + 2, wr && disp_sweep, wr, rd, idx, addr, W'(diff));
    endfunction

    task automatic model_reset();
        hist.delete();
        sweeps_done = 0;
        prev_diff   = 0;
    endtask

    // mode: 0 drop valid after accept, 1 hold valid, 2 random valid during sweep.
    task automatic do_sample(input int s, input int mode, input int abort_bin, output int waited);
        int old;
        int exp_diff;
        bit disp_sweep;
        i_sample       = W'(s);
        i_sample_valid = 1'b1;
        waited = 0;
        while (!o_sample_ready && waited < 4 * N) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!o_sample_ready) begin
            check_eq("accept_timeout", 64'(o_sample_ready), 64'd1);
            i_sample_valid = 1'b0;
            return;
        end
        old = (hist.size() == N) ? hist[0] : 0;
        exp_diff = sat_w(s - old);
        hist.push_back(s);
        if (hist.size() > N) void'(hist.pop_front());
        disp_sweep = (sweeps_done % D) == (D - 1);
        for (int c = 1; c <= N + 3; c++) begin
            @(posedge clk); #1;
            if (mode == 0 || c == N + 3) i_sample_valid = (mode == 1) ? 1'b1 : 1'b0;
            else if (mode == 2) i_sample_valid = 1'($urandom_range(0, 1));
            if (o_disp_wr_en) disp_seen++;
            check_eq($sformatf("cyc%0d", c), obs_vec(), expect_vec(c, (c == 1) ? prev_diff : exp_diff, disp_sweep));
            if (abort_bin >= 0 && c == abort_bin + 3) begin
                reset_n = 1'b0;
                #1;
                check_eq("abort_zero", obs_vec(), 64'd0);
                i_sample_valid = 1'b0;
                model_reset();
                return;
            end
        end
        prev_diff = exp_diff;
        sweeps_done++;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        i_sample_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_zero", obs_vec(), 64'd0);
        reset_n = 1'b1;
        #1;
        check_eq("rst_ready", 64'(o_sample_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        int v;
        reset_n        = 1'b0;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        disp_seen      = 0;
        model_reset();
        do_reset();

        do_sample(100, 0, -1, w);
        check_eq("diff_100", 64'(o_sample_diff), 64'd100);

        do_reset();
        for (int i = 0; i < N; i++) do_sample(i, 0, -1, w);
        do_sample(1000, 0, -1, w);
        check_eq("diff_1000", 64'(o_sample_diff), 64'd1000);
        do_sample(5, 0, -1, w);
        check_eq("diff_4", 64'(o_sample_diff), 64'd4);

        do_reset();
        for (int i = 0; i < N; i++) do_sample(-32768, 0, -1, w);
        do_sample(32767, 0, -1, w);
        check_eq("sat_max", 64'(o_sample_diff), 64'(32767));
        do_reset();
        for (int i = 0; i < N; i++) do_sample(32767, 0, -1, w);
        do_sample(-32768, 0, -1, w);
        check_eq("sat_min", 64'(o_sample_diff), 64'(-32768));

        do_reset();
        disp_seen = 0;
        for (int i = 0; i < 8; i++) do_sample(i * 7 - 20, 0, -1, w);
        check_eq("disp_total", 64'(disp_seen), 64'(2 * N));

        for (int i = 0; i < 4; i++) begin
            do_sample(300 + i, 1, -1, w);
            check_eq("b2b_wait", 64'(w), 64'd0);
        end
        i_sample_valid = 1'b0;

        do_sample(77, 0, 20, w);
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_hold", obs_vec(), 64'd0);
        reset_n = 1'b1;
        #1;
        check_eq("abort_ready", 64'(o_sample_ready), 64'd1);
        @(posedge clk); #1;
        do_sample(-1234, 0, -1, w);
        check_eq("post_abort", 64'(o_sample_diff), 64'(-1234));

        for (int i = 0; i < 3 * N; i++) begin
            case ($urandom_range(0, 3))
                0:       v = -32768;
                1:       v = 32767;
                default: v = int'($urandom_range(0, 65535)) - 32768;
            endcase
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            do_sample(v, ($urandom_range(0, 1) == 1) ? 2 : 0, -1, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stft_sample_seq.md
STFT_SAMPLE_SEQ -- requirements
Module: stft_sample_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: signed sample and diff width.
REQ-002 SHALL have parameter FFT_SIZE, default 512: window length and bin count, power of two.
REQ-003 SHALL have parameter DISP_DECIM, default 4: display updates once every DISP_DECIM sweeps.
REQ-004 SHALL have port clk  in  1: single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_sample_valid  in  1: new audio sample offered.
REQ-007 SHALL have port i_sample  in  WORD_WIDTH: signed audio sample.
REQ-008 SHALL have port o_sample_ready  out  1: sample accepted when valid & ready.
REQ-009 SHALL have port o_sample_diff  out  WORD_WIDTH: signed x[n] - x[n-FFT_SIZE], held for the whole sweep.
REQ-010 SHALL have port o_rd_en  out  1: read strobe to the twiddle ROM and the Xk RAM.
REQ-011 SHALL have port o_rd_addr  out  clog2(FFT_SIZE): bin address k for both memories.
REQ-012 SHALL have port o_idx  out  clog2(FFT_SIZE): bin index to the SPU, aligned with the 1-cycle memory read data.
REQ-013 SHALL have port o_wr_en  out  1: SPU write enable, aligned with o_idx.
REQ-014 SHALL have port o_disp_wr_en  out  1: SPU display write enable.
REQ-015 SHALL have port o_frame_done  out  1: one-cycle pulse on the last bin of a sweep.

Function
REQ-016 SHALL implement FSM IDLE -> DIFF -> SWEEP -> DRAIN -> IDLE.
REQ-017 SHALL assert o_sample_ready only in IDLE; valid is ignored in all other states.
REQ-018 On accept at cycle 0: register sample, read the delay line at write pointer wp, enter DIFF.
REQ-019 In DIFF (cycle 1): register o_sample_diff = sample - old, write sample at wp, wp = wp+1 modulo FFT_SIZE, enter SWEEP.
REQ-020 Diff SHALL be computed at WORD_WIDTH+1 bits, then saturated to WORD_WIDTH: max 2^(W-1)-1, min -2^(W-1).
REQ-021 While fewer than FFT_SIZE samples have been accepted since reset, old SHALL be taken as 0, tracked by a fill counter that saturates at FFT_SIZE.
REQ-022 SWEEP SHALL last FFT_SIZE cycles (cycles 2..FFT_SIZE+1), with o_rd_en=1 and o_rd_addr = 0,1,...,FFT_SIZE-1.
REQ-023 o_idx/o_wr_en SHALL be o_rd_addr/o_rd_en delayed one cycle; o_wr_en is high for cycles 3..FFT_SIZE+2.
REQ-024 DRAIN (cycle FFT_SIZE+2) SHALL carry the final o_wr_en (o_idx=FFT_SIZE-1), pulse o_frame_done, and return to IDLE; ready=1 at cycle FFT_SIZE+3.
REQ-025 A sweep counter SHALL count 0..DISP_DECIM-1 and wrap; o_disp_wr_en = o_wr_en when the count equals DISP_DECIM-1; the count advances at o_frame_done.
REQ-026 o_rd_addr and o_idx SHALL be 0 whenever not enabled.
REQ-027 A sample offered in the same cycle as o_frame_done SHALL NOT be accepted; it is taken the next cycle if valid is still held.
REQ-028 Maximum throughput SHALL be one sample per FFT_SIZE+3 cycles.

Reset
REQ-029 On reset_n low, asynchronously: FSM=IDLE; wp, fill, sweep counter, bin counter=0; o_sample_diff, o_rd_en, o_rd_addr, o_idx, o_wr_en, o_disp_wr_en, o_frame_done=0; o_sample_ready=0 while reset is asserted, 1 in the first cycle after release.
REQ-030 Reset mid-sweep SHALL abort the sweep immediately with no further write enables; delay-line contents are not cleared, and the fill counter masks them.

Structure
REQ-031 A shared package stft_pkg SHALL hold WORD_WIDTH, FFT_SIZE, DISP_DECIM defaults and the FSM state encoding.
REQ-032 The delay line SHALL be sub-module sample_ram: simple dual-port, FFT_SIZE x WORD_WIDTH, 1-cycle synchronous read, no reset.

Verification
REQ-033 Reset, then one sample 100 -> diff=100, o_wr_en high cycles 3..514 with o_idx 0..511, frame_done at cycle 514, ready at 515.
REQ-034 Feed 512 samples, value i, then sample 1000 -> final diff = 1000-0 = 1000; the next sample 5 -> diff 5-1 = 4.
REQ-035 Fill with -32768, then sample 32767 -> diff saturates to 32767; reverse case -> -32768.
REQ-036 Run 8 back-to-back sweeps, DISP_DECIM=4 -> o_disp_wr_en is active only in sweeps 4 and 8, for all 512 bins.
REQ-037 Hold valid high continuously -> exactly one accept per 515 cycles, and no accept in frame_done cycles.
REQ-038 Assert reset_n low at bin 200 -> all outputs 0 immediately; the next sample after release has diff = sample (fill=0).
